// File: rtl/swap_pkg.sv
// Shared types and default widths for the swap skid stage.
// Optional statistics counters are controlled by the SWAP_STATS_EN macro.
package swap_pkg;

   localparam int W_DEF  = 8;
   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   // Layout of one buffered entry at the default width; the buffer stores the same {a, b, swapped} packing.
   typedef struct packed {
      logic [W_DEF-1:0] a;
      logic [W_DEF-1:0] b;
      logic             swapped;
   } swap_pair_t;

endpackage

// File: rtl/swap_skid_buf.sv
// Two-entry skid buffer: head register drives the output, skid register catches
// the one pair accepted while the head is stalled. Handshake outputs decode from state only.
module swap_skid_buf
   import swap_pkg::*;
#(
   parameter int DW = 2*W_DEF+1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);

   skid_state_t   state_q, state_d;
   logic [DW-1:0] head_q, skid_q;
   logic          push, pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (push) state_d = ONE;
         ONE: begin
            if (push && !pop)      state_d = FULL;
            else if (pop && !push) state_d = EMPTY;
         end
         FULL:  if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         EMPTY: in_ready = 1'b1;
         ONE: begin
            in_ready  = 1'b1;
            out_valid = 1'b1;
         end
         FULL:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Storage: new pairs go to head unless the head is held, in which case they land in skid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         unique case (state_q)
            EMPTY: if (push) head_q <= in_data;
            ONE: begin
               if (push && pop) head_q <= in_data;
               else if (push)   skid_q <= in_data;
            end
            FULL:  if (pop) head_q <= skid_q;
            default: ;
         endcase
      end
   end

   assign out_data = head_q;

endmodule

// File: rtl/swap_skid_stage.sv
// Pair-exchange stage: swaps (a,b) on request and queues the result in a 2-entry skid buffer.
// Define SWAP_STATS_EN to add saturating swap/transfer counters.
module swap_skid_stage
   import swap_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_a,
   input  logic [W-1:0]  in_b,
   input  logic          in_swap,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_a,
   output logic [W-1:0]  out_b,
   output logic          out_swapped
`ifdef SWAP_STATS_EN
   ,
   output logic [CW-1:0] swap_cnt,
   output logic [CW-1:0] xfer_cnt
`endif
);

   localparam int EW = 2*W+1;

   logic [EW-1:0] in_ent, out_ent;

   assign in_ent = in_swap ? {in_b, in_a, 1'b1} : {in_a, in_b, 1'b0};

   swap_skid_buf #(.DW(EW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_ent),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_ent)
   );

   assign {out_a, out_b, out_swapped} = out_ent;

`ifdef SWAP_STATS_EN
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
   endfunction

   logic push, pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // Statistics stage: both counters may step in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         swap_cnt <= '0;
         xfer_cnt <= '0;
      end else begin
         if (push && in_swap) swap_cnt <= sat_inc(swap_cnt);
         if (pop)             xfer_cnt <= sat_inc(xfer_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_swap_skid_stage.sv
// Scoreboard bench for swap_skid_stage; counter checks are active when SWAP_STATS_EN is defined.
module tb_swap_skid_stage;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          in_swap = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic          out_swapped;
`ifdef SWAP_STATS_EN
   logic [CW-1:0] swap_cnt;
   logic [CW-1:0] xfer_cnt;
`endif

   swap_skid_stage #(.W(W), .CW(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_swap     (in_swap),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_swapped (out_swapped)
`ifdef SWAP_STATS_EN
      ,
      .swap_cnt    (swap_cnt),
      .xfer_cnt    (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [2*W:0]  q[$];
   logic [CW-1:0] m_swap = '0;
   logic [CW-1:0] m_xfer = '0;
   int            n_chk  = 0;
   int            n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [CW-1:0] m_sat(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + 1'b1;
   endfunction

   // One clock: drive at negedge, check against the scoreboard, update the model.
   task automatic cycle(input logic iv, input logic ordy, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s);
      logic push, pop;
      @(negedge clk);
      in_valid = iv; out_ready = ordy; in_a = a; in_b = b; in_swap = s;
      #1;
      check("in_ready", 32'(in_ready), 32'(q.size() < 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) check("head", 32'({out_a, out_b, out_swapped}), 32'(q[0]));
`ifdef SWAP_STATS_EN
      check("swap_cnt", 32'(swap_cnt), 32'(m_swap));
      check("xfer_cnt", 32'(xfer_cnt), 32'(m_xfer));
`endif
      push = iv && (q.size() < 2);
      pop  = ordy && (q.size() != 0);
      if (pop) begin
         void'(q.pop_front());
         m_xfer = m_sat(m_xfer);
      end
      if (push) begin
         q.push_back(s ? {b, a, 1'b1} : {a, b, 1'b0});
         if (s) m_swap = m_sat(m_swap);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      in_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_a", 32'(out_a), 32'd0);
      check("rst_out_b", 32'(out_b), 32'd0);
      check("rst_out_swapped", 32'(out_swapped), 32'd0);
`ifdef SWAP_STATS_EN
      check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
      check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
`endif
      q.delete();
      m_swap = '0;
      m_xfer = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      do_reset();

      // Mid-stream reset: fill the buffer, then reset while it holds two pairs.
      cycle(1'b1, 1'b0, 8'hA1, 8'hB2, 1'b1);
      cycle(1'b1, 1'b0, 8'hC3, 8'hD4, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      do_reset();

      // Single swapped pair.
      cycle(1'b1, 1'b1, 8'h12, 8'h34, 1'b1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("t2_out_valid", 32'(out_valid), 32'd1);
      check("t2_out_a", 32'(out_a), 32'h34);
      check("t2_out_b", 32'(out_b), 32'h12);
      check("t2_out_swapped", 32'(out_swapped), 32'd1);
      cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);

      // Stalled output: three offered, two accepted, then drain in order.
      cycle(1'b1, 1'b0, 8'h01, 8'h02, 1'b0);
      cycle(1'b1, 1'b0, 8'h03, 8'h04, 1'b1);
      cycle(1'b1, 1'b0, 8'h05, 8'h06, 1'b0);
      check("t3_in_ready_full", 32'(in_ready), 32'd0);
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);

      // Streaming at full rate.
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 1'b1, 8'(i * 7 + 1), 8'(~i), 1'(i % 2));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);

      // Twenty swapped pairs to drive both 4-bit counters into saturation.
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 1'b1, 8'(i), 8'(i + 100), 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
`ifdef SWAP_STATS_EN
      @(negedge clk);
      #1;
      check("t5_swap_cnt_sat", 32'(swap_cnt), 32'hF);
      check("t5_xfer_cnt_sat", 32'(xfer_cnt), 32'hF);
`endif

      // Random handshake traffic.
      for (int i = 0; i < 1000; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      check("final_empty", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
